// File: rtl/clk_div_bank_pkg.sv
// Shared types for the clock divider bank: channel output mode encoding.
package clk_div_bank_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } div_mode_e;

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle of the divider bank; the bench drives master, the bank is slave.
interface clk_div_bank_if #(
  parameter int NCH    = 4,
  parameter int CW     = 26,
  parameter int SCAN_W = 2
);
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    mode;
  logic              load;
  logic [NCH-1:0]    ld_mask;
  logic [NCH*CW-1:0] div_in;
  logic [NCH-1:0]    out;
  logic [NCH-1:0]    tick;
  logic [SCAN_W-1:0] scan_sel;

  modport master (
    output en, mode, load, ld_mask, div_in,
    input  out, tick, scan_sel
  );

  modport slave (
    input  en, mode, load, ld_mask, div_in,
    output out, tick, scan_sel
  );
endinterface

// File: rtl/clk_div_chan.sv
// One programmable divider channel: registered square/pulse output plus a one-cycle tick.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int          CW      = 26,
  parameter int unsigned DEF_DIV = 50000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mode,
  input  logic          load,
  input  logic [CW-1:0] div_in,
  output logic          out,
  output logic          tick
);

  localparam int            CNW       = CW + 1;
  localparam logic [CW-1:0] DEF_DIV_W = CW'(DEF_DIV);

  logic [CW-1:0] div_reg;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;
  logic          terminal;
  div_mode_e     mode_e;

  // One extra bit keeps a divisor of all-ones reachable without wrap.
  assign cnt_inc  = {1'b0, cnt} + CNW'(1);
  assign terminal = (cnt_inc == {1'b0, div_reg});
  assign mode_e   = div_mode_e'(mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= DEF_DIV_W;
      cnt     <= '0;
      out     <= 1'b0;
      tick    <= 1'b0;
    end else if (load) begin
      div_reg <= div_in;
      cnt     <= '0;
      tick    <= 1'b0;
    end else if (!en || div_reg == '0) begin
      cnt  <= '0;
      tick <= 1'b0;
      out  <= 1'b0;
    end else if (terminal) begin
      cnt  <= '0;
      tick <= 1'b1;
      out  <= (mode_e == MODE_PULSE) ? 1'b1 : ~out;
    end else begin
      cnt  <= cnt_inc[CW-1:0];
      tick <= 1'b0;
      if (mode_e == MODE_PULSE) out <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers plus a free-running prescaler for display scan select.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int          CW       = 26,
  parameter int unsigned DEF_DIV  = 50000000,
  parameter int          SCAN_W   = 2,
  parameter int          SCAN_LSB = 15
) (
  input logic           clk,
  input logic           rst_n,
  clk_div_bank_if.slave bus
);

  localparam int PW = SCAN_LSB + SCAN_W;

  logic [NCH-1:0] out_w;
  logic [NCH-1:0] tick_w;
  logic [PW-1:0]  presc;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.en[i]),
      .mode   (bus.mode[i]),
      .load   (bus.load & bus.ld_mask[i]),
      .div_in (bus.div_in[i*CW +: CW]),
      .out    (out_w[i]),
      .tick   (tick_w[i])
    );
  end

  // Prescaler ignores en/load so scan timing never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + PW'(1);
  end

  assign bus.out      = out_w;
  assign bus.tick     = tick_w;
  assign bus.scan_sel = presc[SCAN_LSB +: SCAN_W];

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank with CW=8, DEF_DIV=6, SCAN_LSB=2, SCAN_W=2.
module tb_clk_div_bank;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  clk_div_bank_if #(.NCH(4), .CW(8), .SCAN_W(2)) bus ();

  clk_div_bank #(
    .NCH      (4),
    .CW       (8),
    .DEF_DIV  (6),
    .SCAN_W   (2),
    .SCAN_LSB (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  mode;
    logic        load;
    logic [3:0]  mask;
    logic [31:0] div;
    logic [3:0]  exp_out;
    logic [3:0]  exp_tick;
  } vec_t;

  vec_t vecs [11];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one set of inputs, let one rising edge pass, then settle 1 time unit past it.
  task automatic applyStimulus(input logic [3:0] en_v, input logic [3:0] mode_v,
                               input logic load_v, input logic [3:0] mask_v,
                               input logic [31:0] div_v);
    bus.en      = en_v;
    bus.mode    = mode_v;
    bus.load    = load_v;
    bus.ld_mask = mask_v;
    bus.div_in  = div_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    bus.en      = '0;
    bus.mode    = '0;
    bus.load    = 1'b0;
    bus.ld_mask = '0;
    bus.div_in  = '0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int first_tick;
    int second_tick;
    int n_ticks;
    checks   = 0;
    failures = 0;

    // Reset state, then prescaler stepping with load/en activity on the channels.
    bus.en      = '0;
    bus.mode    = '0;
    bus.load    = 1'b0;
    bus.ld_mask = '0;
    bus.div_in  = '0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out", 32'(bus.out), 32'h0);
    checkOutput("reset tick", 32'(bus.tick), 32'h0);
    checkOutput("reset scan_sel", 32'(bus.scan_sel), 32'h0);
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(4'(n), 4'b0000, 1'(n % 2), 4'b1111, 32'h03030303);
      checkOutput($sformatf("scan_sel n=%0d", n), 32'(bus.scan_sel), 32'((n / 4) % 4));
    end

    // ch0 toggle mode, divisor 5, then a load landing on its terminal cycle.
    resetDut();
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0001, 32'h00000005);
    checkOutput("load edge tick0", 32'(bus.tick[0]), 32'h0);
    for (int j = 0; j < 19; j++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 32'h0);
      checkOutput($sformatf("div5 tick0 j=%0d", j), 32'(bus.tick[0]), 32'((j + 1) % 5 == 0));
      checkOutput($sformatf("div5 out0 j=%0d", j), 32'(bus.out[0]), 32'(((j + 1) / 5) % 2));
    end
    applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b0001, 32'h00000007);
    checkOutput("collision tick0", 32'(bus.tick[0]), 32'h0);
    checkOutput("collision out0 held", 32'(bus.out[0]), 32'h1);
    for (int m = 1; m <= 7; m++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 32'h0);
      checkOutput($sformatf("div7 tick0 m=%0d", m), 32'(bus.tick[0]), 32'(m == 7));
      checkOutput($sformatf("div7 out0 m=%0d", m), 32'(bus.out[0]), 32'(m != 7));
    end

    // Table: ch1 pulse div 3, ch2 div 1, ch3 div 0, masked reload of ch1, mode switch on ch2.
    resetDut();
    vecs[0]  = '{4'b0000, 4'b0010, 1'b1, 4'b1110, 32'h00010300, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b1110, 4'b0010, 1'b0, 4'b0000, 32'h00000000, 4'b0100, 4'b0100};
    vecs[2]  = '{4'b1110, 4'b0010, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 4'b0100};
    vecs[3]  = '{4'b1110, 4'b0010, 1'b0, 4'b0000, 32'h00000000, 4'b0110, 4'b0110};
    vecs[4]  = '{4'b1110, 4'b0010, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 4'b0100};
    vecs[5]  = '{4'b1110, 4'b0010, 1'b0, 4'b0000, 32'h00000000, 4'b0100, 4'b0100};
    vecs[6]  = '{4'b1110, 4'b0010, 1'b0, 4'b0000, 32'h00000000, 4'b0010, 4'b0110};
    vecs[7]  = '{4'b1110, 4'b0010, 1'b1, 4'b0010, 32'h02020202, 4'b0110, 4'b0100};
    vecs[8]  = '{4'b1110, 4'b0010, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 4'b0100};
    vecs[9]  = '{4'b1110, 4'b0010, 1'b0, 4'b0000, 32'h00000000, 4'b0110, 4'b0110};
    vecs[10] = '{4'b1110, 4'b0110, 1'b0, 4'b0000, 32'h00000000, 4'b0100, 4'b0100};
    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].en, vecs[v].mode, vecs[v].load, vecs[v].mask, vecs[v].div);
      checkOutput($sformatf("vec%0d out", v), 32'(bus.out), 32'(vecs[v].exp_out));
      checkOutput($sformatf("vec%0d tick", v), 32'(bus.tick), 32'(vecs[v].exp_tick));
    end

    // Largest divisor: tick on ch3 every 255 cycles.
    resetDut();
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b1000, 32'hFF000000);
    first_tick  = -1;
    second_tick = -1;
    n_ticks     = 0;
    for (int j = 0; j < 510; j++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b0, 4'b0000, 32'h0);
      if (bus.tick[3]) begin
        n_ticks++;
        if (first_tick < 0) first_tick = j;
        else if (second_tick < 0) second_tick = j;
      end
    end
    checkOutput("div255 first tick edge", 32'(first_tick), 32'd254);
    checkOutput("div255 second tick edge", 32'(second_tick), 32'd509);
    checkOutput("div255 tick count", 32'(n_ticks), 32'd2);

    // Enable drop on ch2 while its output is high, then re-enable.
    resetDut();
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0100, 32'h00040000);
    for (int j = 0; j < 5; j++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h0);
      checkOutput($sformatf("div4 tick2 j=%0d", j), 32'(bus.tick[2]), 32'(j == 3));
      checkOutput($sformatf("div4 out2 j=%0d", j), 32'(bus.out[2]), 32'(j >= 3));
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0);
    checkOutput("en drop out2", 32'(bus.out[2]), 32'h0);
    checkOutput("en drop tick2", 32'(bus.tick[2]), 32'h0);
    for (int r = 0; r < 4; r++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h0);
      checkOutput($sformatf("reen tick2 r=%0d", r), 32'(bus.tick[2]), 32'(r == 3));
      checkOutput($sformatf("reen out2 r=%0d", r), 32'(bus.out[2]), 32'(r == 3));
    end

    // Asynchronous reset between edges while ch2 is high and scan_sel is non-zero.
    checkOutput("pre-reset scan_sel", 32'(bus.scan_sel), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out", 32'(bus.out), 32'h0);
    checkOutput("async reset tick", 32'(bus.tick), 32'h0);
    checkOutput("async reset scan_sel", 32'(bus.scan_sel), 32'h0);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b0, 4'b0000, 32'h0);
      checkOutput($sformatf("default div tick j=%0d", j), 32'(bus.tick),
                  (j == 5) ? 32'hF : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
